gardner_ted: RTL

//   Gardner timing error detector feeding the Gardner timing corrector. Runs at 32.768 MHz, takes the
//   32x-oversampled I/Q stream and the corrector's 1.024 MHz symbol strobe and sampled symbols.

---
 rtl/gardner_pkg.sv | 27 ++
 rtl/gardner_ted_if.sv | 25 ++
 rtl/gardner_sat.sv | 23 ++
 rtl/gardner_ted.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gardner_pkg.sv
// rtl/gardner_pkg.sv - shared constants, state type and timing helpers for the Gardner timing loop
package gardner_pkg;

    localparam int SPS_DEFAULT = 32;
    localparam int HALF_SPS    = SPS_DEFAULT / 2;
    localparam int LOST_LIMIT  = 2 * SPS_DEFAULT - 1;

    // Corrector NCO step for the nominal symbol rate: 2^32 / SPS_DEFAULT.
    localparam logic [31:0] INCREMENT_NOMINAL = 32'h0800_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        PRIME = 3'b010,
        TRACK = 3'b100
    } gardner_state_t;

    // Phase-counter value on the cycle before the mid-symbol sample is latched.
    function automatic int mid_index(input int sps);
        return sps / 2 - 1;
    endfunction

    // Phase-counter saturation value; reaching it means strobes have been lost.
    function automatic int lost_index(input int sps);
        return 2 * sps - 1;
    endfunction

endpackage

// File: rtl/gardner_ted_if.sv
// rtl/gardner_ted_if.sv - sample/symbol inputs and error outputs of the Gardner detector
// master: sample source + corrector side (drives I_32M, Q_32M, sym_strobe, I_1M, Q_1M)
// slave : gardner_ted (drives error_n, err_valid, locked_out)
interface gardner_ted_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] I_32M;
    logic signed [WIDTH-1:0] Q_32M;
    logic                    sym_strobe;
    logic signed [WIDTH-1:0] I_1M;
    logic signed [WIDTH-1:0] Q_1M;
    logic signed [WIDTH-1:0] error_n;
    logic                    err_valid;
    logic                    locked_out;

    modport master (
        output I_32M, Q_32M, sym_strobe, I_1M, Q_1M,
        input  error_n, err_valid, locked_out
    );

    modport slave (
        input  I_32M, Q_32M, sym_strobe, I_1M, Q_1M,
        output error_n, err_valid, locked_out
    );
endinterface

// File: rtl/gardner_sat.sv
// rtl/gardner_sat.sv - signed saturating narrower from IN_W to OUT_W bits
// din  in  IN_W   signed value
// dout out OUT_W  din clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module gardner_sat #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);
    localparam int EXT = IN_W - OUT_W + 1;

    // The value fits when every bit from the target sign bit upward agrees.
    logic [EXT-1:0] top;
    assign top = din[IN_W-1:OUT_W-1];

    always_comb begin
        dout = din[OUT_W-1:0];
        if (!(&top) && (|top)) begin
            dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/gardner_ted.sv
// rtl/gardner_ted.sv - Gardner timing error detector driving the corrector's negated error input
// Optional PI loop filter: define GARDNER_TED_LOOP_FILTER_EN.
// clk  in  32.768 MHz clock        rst  in  asynchronous active-high reset
// bus  slave: I_32M/Q_32M samples, sym_strobe, I_1M/Q_1M symbols in;
//             error_n (negated error, held), err_valid (1-cycle), locked_out (TRACK) out
module gardner_ted
    import gardner_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SPS      = SPS_DEFAULT,
    parameter int KI_SHIFT = 6
) (
    input  logic        clk,
    input  logic        rst,
    gardner_ted_if.slave bus
);
    localparam int CW = $clog2(2 * SPS);
    localparam int PW = 2 * WIDTH + 2;
    localparam int SW = 2 * WIDTH + 3;
    localparam logic [CW-1:0] MID_CNT  = CW'(mid_index(SPS));
    localparam logic [CW-1:0] LOST_CNT = CW'(lost_index(SPS));

    if (SPS < 4 || KI_SHIFT < 0 || KI_SHIFT >= WIDTH) begin : g_bad_params
        $error("gardner_ted: unsupported SPS or KI_SHIFT");
    end

    gardner_state_t state, state_next;
    logic do_compute, do_load;
    logic compute_d, load_d;

    logic [CW-1:0]           cnt;
    logic signed [WIDTH-1:0] mid_i, mid_q, prev_i, prev_q;
    logic                    mid_ok;

    logic signed [WIDTH:0]   d_i, d_q;
    logic signed [WIDTH-1:0] m_i, m_q;
    logic signed [PW-1:0]    di_x, dq_x, mi_x, mq_x, p_i, p_q;
    logic signed [SW-1:0]    sum, scaled;
    logic signed [WIDTH-1:0] e_s_c, e_s, x, err_c, error_q;
    logic signed [WIDTH:0]   neg_x;
    logic                    v1, v2, v3, valid_q;

    // Phase counter and mid-symbol capture. A strobe on the capture cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            mid_i  <= '0;
            mid_q  <= '0;
            mid_ok <= 1'b0;
        end else if (bus.sym_strobe) begin
            cnt    <= '0;
            mid_ok <= 1'b0;
        end else begin
            if (cnt != LOST_CNT) cnt <= cnt + CW'(1);
            if (cnt == MID_CNT) begin
                mid_i  <= bus.I_32M;
                mid_q  <= bus.Q_32M;
                mid_ok <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Decisions are taken on the strobe edge (mid_ok is cleared on that same edge);
    // the resulting action is applied one clk later when the symbol is valid.
    always_comb begin
        state_next = state;
        do_compute = 1'b0;
        do_load    = 1'b0;
        if (bus.sym_strobe) begin
            case (state)
                IDLE: begin
                    state_next = PRIME;
                    do_load    = 1'b1;
                end
                PRIME, TRACK: begin
                    if (mid_ok) begin
                        state_next = TRACK;
                        do_compute = 1'b1;
                    end else begin
                        state_next = PRIME;
                        do_load    = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (cnt == LOST_CNT) begin
            state_next = IDLE;
        end
    end

    assign bus.locked_out = (state == TRACK);

    // Symbol capture + S1 (differences).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compute_d <= 1'b0;
            load_d    <= 1'b0;
            prev_i    <= '0;
            prev_q    <= '0;
            d_i       <= '0;
            d_q       <= '0;
            m_i       <= '0;
            m_q       <= '0;
            v1        <= 1'b0;
        end else begin
            compute_d <= do_compute;
            load_d    <= do_load;
            v1        <= compute_d;
            if (compute_d) begin
                d_i <= {prev_i[WIDTH-1], prev_i} - {bus.I_1M[WIDTH-1], bus.I_1M};
                d_q <= {prev_q[WIDTH-1], prev_q} - {bus.Q_1M[WIDTH-1], bus.Q_1M};
                m_i <= mid_i;
                m_q <= mid_q;
            end
            if (compute_d || load_d) begin
                prev_i <= bus.I_1M;
                prev_q <= bus.Q_1M;
            end
        end
    end

    // S2 products at full width, S3 sum / scale / saturate.
    assign di_x   = {{(PW-WIDTH-1){d_i[WIDTH]}}, d_i};
    assign dq_x   = {{(PW-WIDTH-1){d_q[WIDTH]}}, d_q};
    assign mi_x   = {{(PW-WIDTH){m_i[WIDTH-1]}}, m_i};
    assign mq_x   = {{(PW-WIDTH){m_q[WIDTH-1]}}, m_q};
    assign sum    = {p_i[PW-1], p_i} + {p_q[PW-1], p_q};
    assign scaled = sum >>> (WIDTH - 1);

    gardner_sat #(.IN_W(SW), .OUT_W(WIDTH)) u_sat_e (.din(scaled), .dout(e_s_c));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_i <= '0;
            p_q <= '0;
            v2  <= 1'b0;
            e_s <= '0;
            v3  <= 1'b0;
        end else begin
            p_i <= di_x * mi_x;
            p_q <= dq_x * mq_x;
            v2  <= v1;
            v3  <= v2;
            if (v2) e_s <= e_s_c;
        end
    end

`ifdef GARDNER_TED_LOOP_FILTER_EN
    logic signed [WIDTH+1:0] acc, acc_next;
    logic signed [WIDTH-1:0] e_ki;
    logic signed [WIDTH+2:0] acc_sum, x_sum;

    assign e_ki    = e_s >>> KI_SHIFT;
    assign acc_sum = {acc[WIDTH+1], acc} + {{3{e_ki[WIDTH-1]}}, e_ki};
    assign x_sum   = {{3{e_s[WIDTH-1]}}, e_s} + {acc[WIDTH+1], acc};

    gardner_sat #(.IN_W(WIDTH+3), .OUT_W(WIDTH+2)) u_sat_acc (.din(acc_sum), .dout(acc_next));
    gardner_sat #(.IN_W(WIDTH+3), .OUT_W(WIDTH))   u_sat_x   (.din(x_sum),   .dout(x));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     acc <= '0;
        else if (state_next == IDLE && state != IDLE) acc <= '0;
        else if (v3)                                  acc <= acc_next;
    end
`else
    assign x = e_s;
`endif

    // S4: negate with saturation so -(-2^(WIDTH-1)) clamps to the positive limit.
    assign neg_x = -{x[WIDTH-1], x};

    gardner_sat #(.IN_W(WIDTH+1), .OUT_W(WIDTH)) u_sat_neg (.din(neg_x), .dout(err_c));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= v3;
            if (v3) error_q <= err_c;
        end
    end

    assign bus.error_n   = error_q;
    assign bus.err_valid = valid_q;

endmodule
